fifo_packer: RTL and testbench

//  Read-side consumer of the sync FIFO: pops narrow DATA_WIDTH words via ren/rdata/empty and packs

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_out_reg.sv | 30 +++
 rtl/fifo_packer.sv | 137 +++++++++++++
 tb/tb_fifo_packer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
// The partial-word flush path is built only when FIFO_PACKER_FLUSH_EN is defined.
package fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_PACK_RATIO = 4;
   localparam int MAX_RATIO      = 32;

   typedef logic [DEF_DATA_WIDTH-1:0]                     lane_t;
   typedef logic [DEF_PACK_RATIO-1:0][DEF_DATA_WIDTH-1:0] word_t;

   // Mask with the lowest n_lanes bits set. Callers cast it down to their lane count.
   function automatic logic [MAX_RATIO-1:0] keep_mask(input int unsigned n_lanes);
      logic [MAX_RATIO-1:0] mask_v;
      if (n_lanes >= 32'(MAX_RATIO)) begin
         mask_v = {MAX_RATIO{1'b1}};
      end else begin
         mask_v = (MAX_RATIO'(1) << n_lanes) - MAX_RATIO'(1);
      end
      return mask_v;
   endfunction

endpackage

// File: rtl/fifo_out_reg.sv
// One-entry valid/ready holding register for the packed output word.
// The payload is opaque here: data alone, or keep mask and data side by side.
module fifo_out_reg
   import fifo_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_WIDTH * DEF_PACK_RATIO
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_payload,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_payload
);

   // A load wins (and may coincide with an accept); an accept alone empties; otherwise hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_payload <= {WIDTH{1'b0}};
      end else if (load) begin
         out_valid   <= 1'b1;
         out_payload <= load_payload;
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_packer.sv
// Pops narrow words from a show-ahead FIFO and packs PACK_RATIO of them into one wide word,
// lane 0 holding the oldest. Optional partial-word flush: define FIFO_PACKER_FLUSH_EN.
module fifo_packer
   import fifo_pkg::*;
#(
   parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int  PACK_RATIO = DEF_PACK_RATIO,
   localparam int CNT_WIDTH  = $clog2(PACK_RATIO)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             fifo_empty,
   input  logic [DATA_WIDTH-1:0]            fifo_rdata,
   output logic                             fifo_ren,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
   output logic [CNT_WIDTH-1:0]             fill
`ifdef FIFO_PACKER_FLUSH_EN
   ,
   input  logic                             flush,
   output logic [PACK_RATIO-1:0]            out_keep
`endif
);

   localparam int                   WORD_WIDTH = DATA_WIDTH * PACK_RATIO;
   localparam logic [CNT_WIDTH-1:0] LAST_LANE  = CNT_WIDTH'(PACK_RATIO - 1);

   // The final lane of a word never lands here; it goes straight from fifo_rdata into the word.
   logic [PACK_RATIO-2:0][DATA_WIDTH-1:0] lanes_r;
   logic [CNT_WIDTH-1:0]                  fill_r;
   logic                                  out_free_s;
   logic                                  last_lane_s;
   logic                                  blocked_s;
   logic                                  pop_s;
   logic                                  full_load_s;
   logic                                  load_s;
   logic [WORD_WIDTH-1:0]                 load_data_s;

   assign out_free_s  = !out_valid || out_ready;
   assign last_lane_s = (fill_r == LAST_LANE);
   assign pop_s       = !rst && !fifo_empty && !blocked_s && (!last_lane_s || out_free_s);
   assign full_load_s = pop_s && last_lane_s;
   assign fifo_ren    = pop_s;
   assign fill        = fill_r;

`ifdef FIFO_PACKER_FLUSH_EN
   logic                             flush_pend_r;
   logic                             flush_take_s;
   logic                             flush_set_s;
   logic [PACK_RATIO-1:0]            load_keep_s;
   logic [WORD_WIDTH+PACK_RATIO-1:0] out_payload_s;

   // A flush that completes a full word needs nothing extra; an empty accumulator is ignored.
   assign blocked_s    = flush_pend_r;
   assign flush_take_s = flush_pend_r && out_free_s;
   assign flush_set_s  = flush && !flush_pend_r && !full_load_s
                         && ((fill_r != {CNT_WIDTH{1'b0}}) || pop_s);
   assign load_s       = full_load_s || flush_take_s;

   // Choose the word entering the output register: completed word or flushed partial.
   always_comb begin
      load_data_s = {fifo_rdata, lanes_r};
      load_keep_s = {PACK_RATIO{1'b1}};
      if (flush_take_s) begin
         load_data_s = {{DATA_WIDTH{1'b0}}, lanes_r};
         load_keep_s = PACK_RATIO'(keep_mask(32'(fill_r)));
      end else begin
         load_data_s = {fifo_rdata, lanes_r};
         load_keep_s = {PACK_RATIO{1'b1}};
      end
   end

   assign {out_keep, out_data} = out_payload_s;

   fifo_out_reg #(
      .WIDTH        (WORD_WIDTH + PACK_RATIO)
   ) u_out_reg (
      .clk          (clk),
      .rst          (rst),
      .load         (load_s),
      .load_payload ({load_keep_s, load_data_s}),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_payload  (out_payload_s)
   );
`else
   assign blocked_s = 1'b0;
   assign load_s    = full_load_s;

   // Only a completed word ever enters the output register.
   always_comb begin
      load_data_s = {fifo_rdata, lanes_r};
   end

   fifo_out_reg #(
      .WIDTH        (WORD_WIDTH)
   ) u_out_reg (
      .clk          (clk),
      .rst          (rst),
      .load         (load_s),
      .load_payload (load_data_s),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_payload  (out_data)
   );
`endif

   // Accumulate popped lanes; wrap on the final lane; stale lanes stay, only the mask qualifies.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lanes_r      <= {(PACK_RATIO-1)*DATA_WIDTH{1'b0}};
         fill_r       <= {CNT_WIDTH{1'b0}};
`ifdef FIFO_PACKER_FLUSH_EN
         flush_pend_r <= 1'b0;
`endif
      end else begin
`ifdef FIFO_PACKER_FLUSH_EN
         if (flush_take_s) begin
            fill_r       <= {CNT_WIDTH{1'b0}};
            flush_pend_r <= 1'b0;
         end else if (flush_set_s) begin
            flush_pend_r <= 1'b1;
         end
`endif
         if (pop_s) begin
            if (last_lane_s) begin
               fill_r <= {CNT_WIDTH{1'b0}};
            end else begin
               lanes_r[fill_r] <= fifo_rdata;
               fill_r          <= fill_r + CNT_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_packer.sv
// Self-checking bench for fifo_packer (DATA_WIDTH=8, PACK_RATIO=4). A queue models the FIFO;
// expected words go to a scoreboard as bytes are queued and are compared on each accept.
// Flush cases run only when FIFO_PACKER_FLUSH_EN is defined.
module tb_fifo_packer;
   import fifo_pkg::*;

   typedef struct {
      logic [7:0] base;
      int         count;
      int         rdy_mode;   // 0 always ready, 1 random, 2 alternating
      bit         toggle;     // hide the FIFO contents every other cycle
      logic [1:0] exp_fill;
   } row_t;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        fifo_empty = 1'b1;
   logic [7:0]  fifo_rdata = 8'h00;
   logic        fifo_ren;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic [1:0]  fill;
   logic        flush = 1'b0;
   logic [3:0]  out_keep;

   int   checks = 0;
   int   errors = 0;
   int   cyc_n  = 0;
   bit   last_ren;
   bit   last_valid;
   lane_t fifo_q[$];
   lane_t pend_q[$];
   exp_t  exp_q[$];
   row_t  rows[6];

   fifo_packer #(.DATA_WIDTH(8), .PACK_RATIO(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_ren   (fifo_ren),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .fill       (fill)
`ifdef FIFO_PACKER_FLUSH_EN
      ,
      .flush      (flush),
      .out_keep   (out_keep)
`endif
   );

`ifndef FIFO_PACKER_FLUSH_EN
   assign out_keep = 4'hF;
`endif

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push_byte(input lane_t b);
      exp_t e;
      fifo_q.push_back(b);
      pend_q.push_back(b);
      if (pend_q.size() == 4) begin
         e.data = {pend_q[3], pend_q[2], pend_q[1], pend_q[0]};
         e.keep = 4'hF;
         exp_q.push_back(e);
         pend_q.delete();
      end
   endtask

   task automatic push_words(input lane_t base, input int count);
      for (int i = 0; i < count; i++) push_byte(base + 8'(i));
   endtask

   // One clock: drive at the falling edge, sample 1 ns later, settle the FIFO model.
   task automatic cycle(input bit rdy, input bit hide, input bit fl);
      exp_t        e;
      logic [31:0] m;
      @(negedge clk);
      out_ready  = rdy;
      flush      = fl;
      fifo_empty = (fifo_q.size() == 0) || hide;
      fifo_rdata = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
      #1;
      chk("ren_while_empty", {31'd0, fifo_ren && fifo_empty}, 32'd0);
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_word", out_data, 32'hxxxxxxxx);
         end else begin
            e = exp_q.pop_front();
            m = 32'd0;
            for (int l = 0; l < 4; l++) if (e.keep[l]) m[l*8 +: 8] = 8'hFF;
            chk("word_data", out_data & m, e.data & m);
`ifdef FIFO_PACKER_FLUSH_EN
            chk("word_keep", {28'd0, out_keep}, {28'd0, e.keep});
`endif
         end
      end
      if (fifo_ren && !fifo_empty) void'(fifo_q.pop_front());
      last_ren   = fifo_ren;
      last_valid = out_valid;
      cyc_n++;
   endtask

   task automatic drain();
      int n = 0;
      while (fifo_q.size() != 0 && n < 400) begin
         cycle(1'b1, 1'b0, 1'b0);
         n++;
      end
      if (n >= 400) chk("drain_timeout", 32'(fifo_q.size()), 32'd0);
      repeat (6) cycle(1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      logic [11:0] ren_h;
      logic [11:0] val_h;
      bit          rdy;
      int          n;
      int          seen;
      exp_t        e;

      rows[0] = '{8'h10,  8, 0, 1'b0, 2'd0};
      rows[1] = '{8'h20,  6, 1, 1'b1, 2'd2};
      rows[2] = '{8'h30,  2, 0, 1'b0, 2'd0};
      rows[3] = '{8'h40, 12, 2, 1'b0, 2'd0};
      rows[4] = '{8'h50,  7, 2, 1'b1, 2'd3};
      rows[5] = '{8'h60,  1, 1, 1'b0, 2'd0};

      // Reset state; FIFO shown non-empty so the forced-low pop is visible.
      fifo_empty = 1'b0;
      fifo_rdata = 8'h5A;
      #2 rst = 1'b1;
      #2;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data",  out_data, 32'd0);
      chk("rst_fill",  {30'd0, fill}, 32'd0);
      chk("rst_ren",   {31'd0, fifo_ren}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      fifo_empty = 1'b1;
      rst = 1'b0;

      // Reset mid-word acts immediately.
      push_words(8'hC0, 2);
      repeat (3) cycle(1'b1, 1'b0, 1'b0);
      chk("mid_fill", {30'd0, fill}, 32'd2);
      push_byte(8'hC2);
      @(negedge clk);
      fifo_empty = 1'b0;
      fifo_rdata = fifo_q[0];
      #1;
      chk("mid_ren_before", {31'd0, fifo_ren}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_fill",  {30'd0, fill}, 32'd0);
      chk("mid_rst_ren",   {31'd0, fifo_ren}, 32'd0);
      fifo_q.delete();
      pend_q.delete();
      exp_q.delete();
      @(negedge clk);
      fifo_empty = 1'b1;
      rst = 1'b0;

      // Table of streams: ready patterns, empty toggling, cumulative fill at the end.
      for (int r = 0; r < 6; r++) begin
         push_words(rows[r].base, rows[r].count);
         n = 0;
         while (fifo_q.size() != 0 && n < 300) begin
            case (rows[r].rdy_mode)
               0:       rdy = 1'b1;
               1:       rdy = 1'($urandom_range(0, 1));
               default: rdy = (n % 2 == 0);
            endcase
            cycle(rdy, rows[r].toggle && (cyc_n % 2 == 1), 1'b0);
            n++;
         end
         if (n >= 300) chk("row_timeout", 32'(r), 32'hFFFFFFFF);
         repeat (6) cycle(1'b1, 1'b0, 1'b0);
         chk("row_sb_empty", 32'(exp_q.size()), 32'd0);
         chk("row_fill", {30'd0, fill}, {30'd0, rows[r].exp_fill});
      end

      // Eight words with ready high: eight back-to-back pops, word 1 cycle after each 4th pop.
      push_words(8'h01, 8);
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, 1'b0, 1'b0);
         ren_h[i] = last_ren;
         val_h[i] = last_valid;
      end
      chk("burst_ren",   {20'd0, ren_h}, 32'h0FF);
      chk("burst_valid", {20'd0, val_h}, 32'h110);
      chk("burst_sb",    32'(exp_q.size()), 32'd0);

      // Sink stalled: first word held, three more pops then stall; release gives no bubble.
      push_words(8'h01, 12);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b0, 1'b0);
         ren_h[i] = last_ren;
      end
      chk("stall_ren",   {22'd0, ren_h[9:0]}, 32'h07F);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data",  out_data, 32'h04030201);
      chk("stall_fill",  {30'd0, fill}, 32'd3);
      cycle(1'b1, 1'b0, 1'b0);
      chk("release_ren", {31'd0, last_ren}, 32'd1);
      cycle(1'b0, 1'b0, 1'b0);
      chk("release_valid", {31'd0, out_valid}, 32'd1);
      chk("release_data",  out_data, 32'h08070605);
      drain();
      chk("stall_sb", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_PACKER_FLUSH_EN
      // Flush after two lanes: partial word with a two-lane mask.
      push_byte(8'hAA);
      push_byte(8'hBB);
      repeat (3) cycle(1'b1, 1'b0, 1'b0);
      chk("flush_pre_fill", {30'd0, fill}, 32'd2);
      e.data = 32'h0000BBAA;
      e.keep = 4'b0011;
      exp_q.push_back(e);
      pend_q.delete();
      cycle(1'b1, 1'b0, 1'b1);
      n = 0;
      while (!last_valid && n < 6) begin
         cycle(1'b1, 1'b0, 1'b0);
         n++;
      end
      chk("flush_seen", {31'd0, last_valid}, 32'd1);
      chk("flush_keep", {28'd0, out_keep}, 32'h3);
      chk("flush_fill", {30'd0, fill}, 32'd0);
      repeat (3) cycle(1'b1, 1'b0, 1'b0);

      // Flush with nothing held and nothing to pop is ignored.
      seen = 0;
      cycle(1'b1, 1'b0, 1'b1);
      seen += int'(last_valid);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, 1'b0);
         seen += int'(last_valid);
      end
      chk("flush_idle_valid", 32'(seen), 32'd0);

      // Flush together with the 4th pop: one ordinary full word only.
      push_words(8'h11, 4);
      repeat (3) cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1);
      chk("flush_full_ren", {31'd0, last_ren}, 32'd1);
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 1'b0);
         if (last_valid) begin
            seen++;
            chk("flush_full_keep", {28'd0, out_keep}, 32'hF);
         end
      end
      chk("flush_full_count", 32'(seen), 32'd1);
      chk("flush_sb", 32'(exp_q.size()), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
